pwm_period_gen: RTL and testbench
=================================

PWM_PERIOD_GEN -- requirements
Module: pwm_period_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the bit width of duty-cycle, switching-period and counter values.
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 i_enable  input  1  1 = generate PWM periods; 0 = stop at the end of the current period.
REQ-005 i_duty_cycle  input  WIDTH  high-time in clocks of the next period; valid while i_duty_cycle_ready=1 (show-ahead from the upstream register-interface FIFO).
REQ-006 i_duty_cycle_ready  input  1  upstream duty-cycle FIFO non-empty.
REQ-007 i_switch_freq  input  WIDTH  period length in clocks of the next period; valid while i_switch_freq_ready=1.
REQ-008 i_switch_freq_ready  input  1  upstream switching-frequency FIFO non-empty.
REQ-009 o_period_start  output  1  one-clock pulse; pops one entry from both upstream FIFOs (drives their i_period_start).
REQ-010 o_pwm  output  1  registered PWM output.
REQ-011 o_busy  output  1  1 in LOAD or RUN.
REQ-012 o_underrun  output  1  one-clock pulse: period boundary reached with i_enable=1 but a FIFO empty.
REQ-013 o_param_err  output  1  one-clock pulse: popped i_switch_freq equal to 0.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, RUN.
REQ-015 IDLE: o_pwm=0, o_busy=0; when i_enable=1 and both ready inputs=1, SHALL go to LOAD.
REQ-016 LOAD (1 clock): SHALL latch i_duty_cycle into duty_q and i_switch_freq into period_q, pulse o_period_start in this same cycle, clear counter to 0, go to RUN; if i_switch_freq=0, SHALL instead pulse o_param_err (entry still popped) and go to IDLE.
REQ-017 RUN: counter SHALL increment by 1 each clock from 0 to period_q-1; o_pwm SHALL be 1 on the clock after a counter value < duty_q is present, else 0 (one clock registered latency).
REQ-018 duty_q >= period_q SHALL give o_pwm=1 for the whole period; duty_q=0 SHALL give o_pwm=0 for the whole period.
REQ-019 At counter=period_q-1 with i_enable=1 and both ready=1, SHALL pop (o_period_start=1), reload duty_q/period_q from inputs and wrap counter to 0 on the same edge, giving back-to-back periods with no gap; popped i_switch_freq=0 SHALL behave as in REQ-016 (error, IDLE).
REQ-020 At counter=period_q-1 with i_enable=1 and either ready=0, SHALL pulse o_underrun, not pop, and repeat the period with the held duty_q/period_q.
REQ-021 At counter=period_q-1 with i_enable=0, SHALL go to IDLE; i_enable deassertion mid-period SHALL NOT truncate the period.
REQ-022 Counter SHALL be WIDTH bits; maximum period 2^WIDTH-1 clocks; no wrap beyond period_q-1.
REQ-023 o_period_start SHALL never be asserted while either ready input is 0; at most one pop per period.
REQ-024 Only one of o_underrun, o_param_err SHALL pulse per boundary; o_param_err takes precedence.

Reset
REQ-025 While i_rst=0: state=IDLE, counter=0, duty_q=0, period_q=0, and o_pwm, o_period_start, o_busy, o_underrun, o_param_err all 0, asynchronously.
REQ-026 Reset asserted mid-period SHALL abort immediately with no pop; after release, operation SHALL restart from IDLE per REQ-015.

Structure
REQ-027 A shared package pwm_pkg SHALL hold the FSM state type (IDLE, LOAD, RUN) and the default WIDTH constant.
REQ-028 The counter with terminal-count detect SHALL be one sub-module, pwm_period_counter (inputs clear/enable/period, outputs count/last).

Verification
REQ-029 Enable with FIFOs holding duty=3, freq=8 -> o_period_start pulses once in LOAD; o_pwm high 3 clocks, low 5 clocks, first high one clock after RUN entry.
REQ-030 Two entries (3,8) then (6,10), enable held -> second pop at counter=7, periods back-to-back, second period high 6 / low 4, no idle gap.
REQ-031 Entries duty=0 freq=4 then duty=9 freq=4 -> first period all low, second all high.
REQ-032 One entry (2,5), enable held, FIFOs then empty -> o_underrun pulse every 5 clocks, pattern 2 high/3 low repeats, no o_period_start.
REQ-033 Entry freq=0 -> o_period_start and o_param_err pulse together, o_pwm stays 0, return to IDLE.
REQ-034 i_rst driven 0 at counter=3 of a (5,10) period -> all outputs 0 within the same clock without an edge; after release and re-enable, fresh LOAD with new pop.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM period generator: FSM state encoding and
// the default datapath width.
package pwm_pkg;

    localparam int PWM_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_period_counter.sv
// Period counter: counts 0 .. i_period-1 while enabled, wraps to 0 after the
// terminal count, and flags the terminal count on o_last.
module pwm_period_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_period,
    output logic [WIDTH-1:0] o_count,
    output logic             o_last
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign o_last  = (count_q == (i_period - ONE));
    assign o_count = count_q;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable) begin
            count_d = o_last ? '0 : (count_q + ONE);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pwm_period_gen.sv
// PWM period generator: pulls (duty, period) pairs from two show-ahead FIFOs
// and produces back-to-back PWM periods with a registered output.
module pwm_period_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_duty_cycle,
    input  logic             i_duty_cycle_ready,
    input  logic [WIDTH-1:0] i_switch_freq,
    input  logic             i_switch_freq_ready,
    output logic             o_period_start,
    output logic             o_pwm,
    output logic             o_busy,
    output logic             o_underrun,
    output logic             o_param_err
);

    pwm_state_e       state_q;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] period_q;
    logic             pwm_q;

    logic [WIDTH-1:0] count;
    logic             last;
    logic             cnt_clear;
    logic             cnt_en;
    logic             fifo_rdy;
    logic             boundary;
    logic             pop;
    logic             freq_zero;

    assign fifo_rdy  = i_duty_cycle_ready & i_switch_freq_ready;
    assign boundary  = (state_q == RUN) & last;
    assign freq_zero = (i_switch_freq == '0);

    // A pop is only ever issued with both FIFOs non-empty, so the FIFOs and
    // this block advance on the same edge.
    assign pop = fifo_rdy & ((state_q == LOAD) | (boundary & i_enable));

    assign o_period_start = pop;
    assign o_param_err    = pop & freq_zero;
    assign o_underrun     = boundary & i_enable & ~fifo_rdy;
    assign o_busy         = (state_q != IDLE);
    assign o_pwm          = pwm_q;

    assign cnt_clear = (state_q != RUN);
    assign cnt_en    = (state_q == RUN);

    pwm_period_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (cnt_clear),
        .i_enable (cnt_en),
        .i_period (period_q),
        .o_count  (count),
        .o_last   (last)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            period_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            pwm_q <= (state_q == RUN) && (count < duty_q);
            case (state_q)
                IDLE: begin
                    if (i_enable && fifo_rdy) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (pop && !freq_zero) begin
                        duty_q   <= i_duty_cycle;
                        period_q <= i_switch_freq;
                        state_q  <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    // Period boundary: stop, reload, or repeat the held values.
                    if (last) begin
                        if (!i_enable) begin
                            state_q <= IDLE;
                        end else if (pop) begin
                            if (freq_zero) begin
                                state_q <= IDLE;
                            end else begin
                                duty_q   <= i_duty_cycle;
                                period_q <= i_switch_freq;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_period_gen.sv
// Scoreboard bench for pwm_period_gen: upstream FIFOs modelled as queues,
// expected per-cycle outputs queued per scenario and compared each cycle.
module tb_pwm_period_gen;

    localparam int W = 8;
    localparam int B_IDLE = 0;
    localparam int B_POP  = 1;
    localparam int B_UND  = 2;
    localparam int B_ERR  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] dc;
    logic         dc_rdy;
    logic [W-1:0] sf;
    logic         sf_rdy;
    logic         o_period_start;
    logic         o_pwm;
    logic         o_busy;
    logic         o_underrun;
    logic         o_param_err;

    logic [W-1:0] q_d[$];
    logic [W-1:0] q_f[$];
    logic [4:0]   exp_q[$];
    logic         carry;
    bit           pend_pop;
    int           checks;
    int           passed;

    always #5 clk = ~clk;

    pwm_period_gen #(.WIDTH(W)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_enable            (en),
        .i_duty_cycle        (dc),
        .i_duty_cycle_ready  (dc_rdy),
        .i_switch_freq       (sf),
        .i_switch_freq_ready (sf_rdy),
        .o_period_start      (o_period_start),
        .o_pwm               (o_pwm),
        .o_busy              (o_busy),
        .o_underrun          (o_underrun),
        .o_param_err         (o_param_err)
    );

    function automatic logic [4:0] mk(input logic busy, input logic start,
                                      input logic und, input logic err,
                                      input logic pwm);
        return {busy, start, und, err, pwm};
    endfunction

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, (i == 0) ? carry : 1'b0));
        end
        carry = 1'b0;
    endtask

    task automatic push_load(input logic err);
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, err, carry));
        carry = 1'b0;
    endtask

    // One RUN period of length p with duty d; len < p truncates it.
    task automatic push_run(input int d, input int p, input int bnd, input int len);
        logic lst;
        logic pw;
        for (int j = 0; j < len; j++) begin
            pw    = carry;
            carry = (j < d);
            lst   = (j == p - 1);
            exp_q.push_back(mk(1'b1,
                               lst && (bnd == B_POP || bnd == B_ERR),
                               lst && (bnd == B_UND),
                               lst && (bnd == B_ERR),
                               pw));
        end
    endtask

    task automatic cyc(input int k, input int dis_at);
        @(negedge clk);
        if (pend_pop) begin
            if (q_d.size() > 0) q_d.delete(0);
            if (q_f.size() > 0) q_f.delete(0);
        end
        pend_pop = 1'b0;
        dc_rdy = (q_d.size() > 0);
        sf_rdy = (q_f.size() > 0);
        dc = dc_rdy ? q_d[0] : '0;
        sf = sf_rdy ? q_f[0] : '0;
        en = (k < dis_at);
        #1;
        if (o_period_start) begin
            pend_pop = 1'b1;
            checks++;
            if (!(dc_rdy && sf_rdy))
                $display("FAIL pop_while_empty cycle %0d: start=1 with ready d=%b f=%b, required both 1",
                         k, dc_rdy, sf_rdy);
            else passed++;
        end
    endtask

    task automatic run_sb(input string name, input int dis_at);
        int k;
        logic [4:0] e;
        logic [4:0] a;
        k = 0;
        while (exp_q.size() > 0) begin
            cyc(k, dis_at);
            e = exp_q.pop_front();
            a = {o_busy, o_period_start, o_underrun, o_param_err, o_pwm};
            checks++;
            if (a !== e)
                $display("FAIL %s cycle %0d: {busy,start,und,err,pwm} got %b required %b",
                         name, k, a, e);
            else passed++;
            k++;
        end
        en = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] a;
        rst = 1'b0; en = 1'b1; dc = 8'd3; sf = 8'd8; dc_rdy = 1'b1; sf_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        a = {o_busy, o_period_start, o_underrun, o_param_err, o_pwm};
        checks++;
        if (a !== 5'b0) $display("FAIL reset_outputs: got %b required 00000", a);
        else passed++;
        en = 1'b0; dc_rdy = 1'b0; sf_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        carry = 1'b0;
        push_idle(2);
        run_sb("reset_idle", 0);
    endtask

    task automatic test_single_period();
        q_d = '{8'd3}; q_f = '{8'd8};
        push_idle(1); push_load(1'b0); push_run(3, 8, B_IDLE, 8); push_idle(2);
        run_sb("single_3_8", 3);
        checks++;
        if (q_d.size() != 0 || q_f.size() != 0)
            $display("FAIL single_pops: fifo left d=%0d f=%0d required 0/0", q_d.size(), q_f.size());
        else passed++;
    endtask

    task automatic test_back_to_back();
        q_d = '{8'd3, 8'd6}; q_f = '{8'd8, 8'd10};
        push_idle(1); push_load(1'b0);
        push_run(3, 8, B_POP, 8); push_run(6, 10, B_IDLE, 10); push_idle(2);
        run_sb("b2b_3_8_6_10", 12);
        checks++;
        if (q_d.size() != 0 || q_f.size() != 0)
            $display("FAIL b2b_pops: fifo left d=%0d f=%0d required 0/0", q_d.size(), q_f.size());
        else passed++;
    endtask

    task automatic test_duty_extremes();
        q_d = '{8'd0, 8'd9}; q_f = '{8'd4, 8'd4};
        push_idle(1); push_load(1'b0);
        push_run(0, 4, B_POP, 4); push_run(9, 4, B_IDLE, 4); push_idle(2);
        run_sb("duty_0_then_9", 7);
    endtask

    task automatic test_underrun();
        // Duty FIFO keeps an entry: only the frequency FIFO runs dry.
        q_d = '{8'd2, 8'd7}; q_f = '{8'd5};
        push_idle(1); push_load(1'b0);
        for (int i = 0; i < 3; i++) push_run(2, 5, B_UND, 5);
        push_run(2, 5, B_IDLE, 5); push_idle(2);
        run_sb("underrun_2_5", 18);
        checks++;
        if (q_d.size() != 1 || q_f.size() != 0)
            $display("FAIL underrun_no_pop: fifo left d=%0d f=%0d required 1/0", q_d.size(), q_f.size());
        else passed++;
        q_d.delete();
    endtask

    task automatic test_param_err();
        q_d = '{8'd4}; q_f = '{8'd0};
        push_idle(1); push_load(1'b1); push_idle(2);
        run_sb("param_err_load", 2);
        checks++;
        if (q_d.size() != 0 || q_f.size() != 0)
            $display("FAIL param_err_load_pop: fifo left d=%0d f=%0d required 0/0", q_d.size(), q_f.size());
        else passed++;
        q_d = '{8'd3, 8'd5}; q_f = '{8'd4, 8'd0};
        push_idle(1); push_load(1'b0); push_run(3, 4, B_ERR, 4); push_idle(2);
        run_sb("param_err_boundary", 100);
        checks++;
        if (q_d.size() != 0 || q_f.size() != 0)
            $display("FAIL param_err_bnd_pop: fifo left d=%0d f=%0d required 0/0", q_d.size(), q_f.size());
        else passed++;
    endtask

    task automatic test_reset_mid_period();
        logic [4:0] a;
        q_d = '{8'd5, 8'd2}; q_f = '{8'd10, 8'd3};
        push_idle(1); push_load(1'b0); push_run(5, 10, B_IDLE, 4);
        run_sb("pre_reset_5_10", 100);
        #1 rst = 1'b0;
        #1;
        a = {o_busy, o_period_start, o_underrun, o_param_err, o_pwm};
        checks++;
        if (a !== 5'b0) $display("FAIL async_reset_outputs: got %b required 00000", a);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        #1;
        a = {o_busy, o_period_start, o_underrun, o_param_err, o_pwm};
        checks++;
        if (a !== 5'b0) $display("FAIL held_reset_outputs: got %b required 00000", a);
        else passed++;
        checks++;
        if (q_d.size() != 1 || q_f.size() != 1)
            $display("FAIL reset_no_pop: fifo left d=%0d f=%0d required 1/1", q_d.size(), q_f.size());
        else passed++;
        rst = 1'b1;
        pend_pop = 1'b0;
        carry = 1'b0;
        push_idle(1); push_load(1'b0); push_run(2, 3, B_IDLE, 3); push_idle(2);
        run_sb("post_reset_2_3", 3);
        checks++;
        if (q_d.size() != 0 || q_f.size() != 0)
            $display("FAIL post_reset_pop: fifo left d=%0d f=%0d required 0/0", q_d.size(), q_f.size());
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        pend_pop = 1'b0;
        carry = 1'b0;
        test_reset();
        test_single_period();
        test_back_to_back();
        test_duty_extremes();
        test_underrun();
        test_param_err();
        test_reset_mid_period();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, passed %0d of %0d", passed, checks);
        $fatal(1, "timeout");
    end

endmodule
